// File: rtl/interval_scheduler_pkg.sv
// Shared types and helpers for interval_scheduler: FSM states, counter width
// default and the round-robin winner picker.
package interval_sched_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Requests above 'last' win first; if none, the lowest set request wins,
    // which makes the requester just served the lowest priority.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] reqs,
                                      input logic [IDX_W-1:0]   last);
        logic [MAX_REQ-1:0] upper;
        logic [MAX_REQ-1:0] masked;
        pick_t              p;
        upper  = ~((8'd2 << last) - 8'd1);
        masked = reqs & upper;
        p      = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (reqs[i]) begin
                p.valid = 1'b1;
                p.idx   = IDX_W'(i);
            end
        end
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                p.idx = IDX_W'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/interval_scheduler_if.sv
// Requester-side bus of interval_scheduler. The abort/aborted pair exists
// only when INTERVAL_SCHED_ABORT_EN is defined.
interface interval_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] len;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [CNT_W-1:0]       cnt;
`ifdef INTERVAL_SCHED_ABORT_EN
    logic                   abort;
    logic                   aborted;

    modport master (
        output req, len, abort,
        input  grant, done, busy, cnt, aborted
    );

    modport slave (
        input  req, len, abort,
        output grant, done, busy, cnt, aborted
    );
`else
    modport master (
        output req, len,
        input  grant, done, busy, cnt
    );

    modport slave (
        input  req, len,
        output grant, done, busy, cnt
    );
`endif

endinterface

// File: rtl/interval_scheduler_counter.sv
// interval_counter: loadable increment-only counter shared by all requesters;
// tcount flags the all-ones value.
module interval_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] preset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tcount
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= preset;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tcount = &cnt;

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin scheduler sharing one interval_counter among N_REQ requesters.
// Optional abort support is compiled in with INTERVAL_SCHED_ABORT_EN.
module interval_scheduler
    import interval_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    interval_scheduler_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_served;
    logic [IDX_W-1:0]   last_next;
    logic [MAX_REQ-1:0] req_pad;
    pick_t              pick;
    logic [CNT_W-1:0]   len_sel;
    logic [CNT_W-1:0]   cnt_val;
    logic               tcount;
    logic               cnt_load;
    logic               cnt_en;
    logic [N_REQ-1:0]   owner_hot;
`ifdef INTERVAL_SCHED_ABORT_EN
    logic               abort_hit;
    logic               aborted_q;
`endif

    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = bus.req;
        pick                 = rr_pick(req_pad, last_served);
    end

    // last_served doubles as the current winner from LOAD through DONE.
    assign len_sel = bus.len[last_served*CNT_W +: CNT_W];

    always_comb begin
        state_next = state;
        last_next  = last_served;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pick.valid) begin
                    state_next = LOAD;
                    last_next  = pick.idx;
                end
            end
            LOAD: begin
                cnt_load   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (tcount) begin
                    state_next = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef INTERVAL_SCHED_ABORT_EN
        abort_hit = bus.abort && ((state == LOAD) || (state == RUN));
        if (abort_hit) begin
            state_next = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= LAST_RST;
        end else begin
            state       <= state_next;
            last_served <= last_next;
        end
    end

`ifdef INTERVAL_SCHED_ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign bus.aborted = aborted_q;
`endif

    // preset = all-ones - len, so the count reaches all-ones after len RUN cycles.
    interval_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load),
        .preset (~len_sel),
        .en     (cnt_en),
        .cnt    (cnt_val),
        .tcount (tcount)
    );

    assign owner_hot = N_REQ'(1) << last_served;
    assign bus.grant = (state != IDLE) ? owner_hot : '0;
    assign bus.done  = (state == DONE) ? owner_hot : '0;
    assign bus.busy  = (state != IDLE);
    assign bus.cnt   = cnt_val;

endmodule

// File: doc/interval_scheduler.md
# interval_scheduler

Round-robin scheduler that shares one loadable 8-bit up-counter between several requesters needing timed intervals. Each requester posts a length, waits for a grant, and gets a one-cycle done pulse when its interval expires. The block owns the counter instance and drives its load, preset and terminal-count path. It sits between the timer-consuming control blocks and the counter resource.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 8, counter width; preset and length width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester interval request, level
- len  in  N_REQ*CNT_W  packed lengths, requester i in bits [i*CNT_W +: CNT_W]
- grant  out  N_REQ  one-hot; high for the granted requester from LOAD through DONE
- done  out  N_REQ  one-cycle pulse, high in DONE for the granted requester
- busy  out  1  high in LOAD, RUN and DONE
- cnt  out  CNT_W  current counter value, for debug

## Operation
- FSM states:
  - IDLE: if any req bit is set, pick the winner and go to LOAD; else stay.
  - LOAD: counter loaded with preset = all-ones − len[winner], then RUN.
  - RUN: counter increments each cycle; on terminal count (cnt == all-ones) go to DONE.
  - DONE: assert done[winner], then IDLE.
- Arbitration:
  - Round-robin. The search starts at last_served+1 mod N_REQ.
  - last_served updates on entry to LOAD and resets to N_REQ−1, so requester 0 wins first.
- Length handling:
  - len is sampled only in LOAD; later changes are ignored for that interval.
  - len = 0 loads all-ones, so tcount is seen in the first RUN cycle.
- Request rules:
  - req is not acknowledged by dropping grant; only done completes an interval.
  - A requester must drop req no later than the cycle after done, unless it wants another interval.
  - A re-request from the requester just served takes lowest priority.
  - Dropping req during LOAD or RUN does not cancel the interval. It completes and done still pulses.
- Counter is an internal increment-only datapath. Wrap-around never occurs in RUN because the FSM leaves on all-ones.
- Reset values: grant = 0, done = 0, busy = 0, cnt = 0, FSM = IDLE, last_served = N_REQ−1.
- Reset asserted mid-interval clears everything asynchronously. No done is emitted, and after release the block restarts in IDLE.

## Timing
- Cycle 0 is the first IDLE cycle with req high.
  - LOAD in cycle 1; grant rises in cycle 1.
  - RUN from cycle 2 with cnt = all-ones − len.
  - tcount in cycle 2+len.
  - DONE and the done pulse in cycle 3+len.
  - IDLE in cycle 4+len.
- Request-to-done latency is len+3 cycles.
- Back-to-back intervals have a minimum 1-cycle IDLE gap; the next grant rises in cycle 5+len.
- All outputs are registered or decoded from state registers only. There is no combinational path from req or len to any output.

## Configuration
- Macro INTERVAL_SCHED_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort high in LOAD or RUN forces IDLE on the next edge.
  - In that same next cycle, aborted pulses for one cycle and grant clears.
  - No done is emitted; last_served is kept.
  - abort in IDLE or DONE is ignored.
- Not defined: no abort port, no aborted port. Every granted interval runs to done.

## Structure
- Shared package interval_sched_pkg holds:
  - state enum: IDLE, LOAD, RUN, DONE;
  - CNT_W default;
  - a round-robin pick function (mask plus priority encode).
- One sub-module, interval_counter: loadable CNT_W up-counter.
  - Inputs: clk, reset, load, preset, en.
  - Outputs: cnt, tcount.
  - The FSM and arbiter stay in the top level.

## Test plan
- Single request, req[0]=1, len0=5 at cycle 0: grant[0] cycles 1–8, done[0] only in cycle 8, busy low in cycle 9.
- len0=0: done[0] in cycle 3. len0=255: cnt=0 in cycle 2, done[0] in cycle 258.
- All four req high with equal len=2: grants in order 0,1,2,3,0. Each done is 6 cycles apart (len+4), with no starvation.
- len changed from 10 to 3 during RUN: done still arrives at cycle 13.
- reset driven low in cycle 4 of a len=10 interval: all outputs 0 immediately. After release, requester 0 is regranted first, with no stray done.
- With INTERVAL_SCHED_ABORT_EN: abort in cycle 3 of len=10 → IDLE and aborted=1 in cycle 4, no done. The next request resumes round-robin after the aborted requester.
